// File: rtl/cnorm_shift_ctrl_pkg.sv
// Shared FFT256 definitions: frame size, sequencer states, shift-code type.
package cnorm_shift_ctrl_pkg;

    localparam int FFT_FRAME = 256;
    localparam int FFT_CNT_W = $clog2(FFT_FRAME);

    typedef logic [1:0] shift_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    // Increment a shift code, saturating at the supplied ceiling.
    function automatic shift_t shift_inc_sat(input shift_t s, input shift_t max_s);
        return (s >= max_s) ? max_s : shift_t'(s + 2'd1);
    endfunction

endpackage

// File: rtl/cnorm_shift_ctrl_shift_policy.sv
// Block-exponent policy: backs the shift off after an overflowing frame and
// grows it after HOLD consecutive clean frames. Updates only on decide.
module cnorm_shift_ctrl_shift_policy
    import cnorm_shift_ctrl_pkg::*;
#(
    parameter int HOLD       = 4,
    parameter int INIT_SHIFT = 2,
    parameter int MAX_SHIFT  = 3
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   decide,
    input  logic   frame_ovf,
    output shift_t shift_nxt,
    output logic   sat
);

    localparam shift_t     INIT_S   = shift_t'(INIT_SHIFT);
    localparam shift_t     MAX_S    = shift_t'(MAX_SHIFT);
    localparam logic [3:0] HOLD_END = 4'(HOLD - 1);

    logic [3:0] clean_cnt;

    // One decision per closed frame; sat is sticky until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_nxt <= INIT_S;
            clean_cnt <= '0;
            sat       <= 1'b0;
        end else if (decide) begin
            if (frame_ovf) begin
                clean_cnt <= '0;
                if (shift_nxt != 2'd0)
                    shift_nxt <= shift_nxt - 2'd1;
                else
                    sat <= 1'b1;
            end else if (clean_cnt == HOLD_END) begin
                clean_cnt <= '0;
                shift_nxt <= shift_inc_sat(shift_nxt, MAX_S);
            end else begin
                clean_cnt <= clean_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/cnorm_shift_ctrl.sv
// CNORM scaling controller: sequences FFT256 frames, accumulates the
// normalizer overflow flag per frame and drives a frame-constant SHIFT code.
module cnorm_shift_ctrl
    import cnorm_shift_ctrl_pkg::*;
#(
    parameter int FRAME      = FFT_FRAME,
    parameter int HOLD       = 4,
    parameter int INIT_SHIFT = 2,
    parameter int MAX_SHIFT  = 3
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   ED,
    input  logic   START,
    input  logic   OVF,
    output shift_t SHIFT,
    output shift_t EXP,
    output logic   EXP_VLD,
    output logic   FRM_OVF,
    output logic   ABORT,
    output logic   SAT
);

    localparam int            CW   = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ovf_acc;
    shift_t        shift_cur;
    shift_t        shift_nxt;
    logic          decide;
    logic          frame_ovf;

    // The TAIL cycle carries the OVF of the last sample, so the frame verdict
    // folds it in combinationally.
    assign decide    = ED && (state == ST_TAIL);
    assign frame_ovf = ovf_acc | OVF;
    assign SHIFT     = shift_cur;

    cnorm_shift_ctrl_shift_policy #(
        .HOLD       (HOLD),
        .INIT_SHIFT (INIT_SHIFT),
        .MAX_SHIFT  (MAX_SHIFT)
    ) u_policy (
        .CLK       (CLK),
        .RST       (RST),
        .decide    (decide),
        .frame_ovf (frame_ovf),
        .shift_nxt (shift_nxt),
        .sat       (SAT)
    );

    // Frame sequencer: counter, overflow accumulation and per-frame reporting.
    // shift_cur only loads on an accepted START so it never moves mid-frame;
    // a START in TAIL picks up shift_nxt before this frame's decision lands.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            shift_cur <= shift_t'(INIT_SHIFT);
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            EXP       <= '0;
            EXP_VLD   <= 1'b0;
            FRM_OVF   <= 1'b0;
            ABORT     <= 1'b0;
        end else begin
            EXP_VLD <= 1'b0;
            FRM_OVF <= 1'b0;
            ABORT   <= 1'b0;
            if (ED) begin
                case (state)
                    ST_IDLE: begin
                        if (START) begin
                            state     <= ST_RUN;
                            shift_cur <= shift_nxt;
                            cnt       <= ONE;
                            ovf_acc   <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (START) begin
                            ABORT     <= 1'b1;
                            shift_cur <= shift_nxt;
                            cnt       <= ONE;
                            ovf_acc   <= 1'b0;
                        end else begin
                            ovf_acc <= ovf_acc | OVF;
                            cnt     <= cnt + ONE;
                            if (cnt == LAST)
                                state <= ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        EXP_VLD <= 1'b1;
                        EXP     <= shift_cur;
                        FRM_OVF <= frame_ovf;
                        ovf_acc <= 1'b0;
                        if (START) begin
                            state     <= ST_RUN;
                            shift_cur <= shift_nxt;
                            cnt       <= ONE;
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnorm_shift_ctrl.sv
// Directed bench for cnorm_shift_ctrl with an EXP/FRM_OVF scoreboard.
module tb_cnorm_shift_ctrl;

    localparam int FRAME = 256;
    localparam int HOLD  = 4;
    localparam int MAXS  = 3;

    logic       CLK = 1'b0;
    logic       RST, ED, START, OVF;
    logic [1:0] SHIFT, EXP;
    logic       EXP_VLD, FRM_OVF, ABORT, SAT;

    always #5 CLK = ~CLK;

    cnorm_shift_ctrl #(
        .FRAME(FRAME), .HOLD(HOLD), .INIT_SHIFT(2), .MAX_SHIFT(MAXS)
    ) dut (
        .CLK(CLK), .RST(RST), .ED(ED), .START(START), .OVF(OVF),
        .SHIFT(SHIFT), .EXP(EXP), .EXP_VLD(EXP_VLD), .FRM_OVF(FRM_OVF),
        .ABORT(ABORT), .SAT(SAT)
    );

    typedef struct packed {
        logic [1:0] exp;
        logic       fo;
    } sb_t;

    sb_t sbq[$];
    int  total = 0;
    int  bad   = 0;

    // reference policy state
    int  m_nxt, m_cur, m_clean;
    bit  m_sat;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input logic ed, input logic st, input logic ov);
        ED = ed; START = st; OVF = ov;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        sbq.delete();
        m_nxt = 2; m_cur = 2; m_clean = 0; m_sat = 0;
    endtask

    function automatic void model_decide(input bit fo);
        if (fo) begin
            m_clean = 0;
            if (m_nxt > 0) m_nxt--;
            else m_sat = 1;
        end else begin
            m_clean++;
            if (m_clean == HOLD) begin
                m_clean = 0;
                m_nxt = (m_nxt + 1 > MAXS) ? MAXS : m_nxt + 1;
            end
        end
    endfunction

    task automatic ed_gaps(input bit rnd_ed);
        // ED-low cycles carry junk START/OVF that must be ignored
        if (rnd_ed)
            while ($urandom_range(0, 2) == 0) tick(1'b0, 1'b1, 1'b1);
    endtask

    // One frame: cycle 0 is sample 0 (START), cycle FRAME is the TAIL cycle.
    // chained_in: sample 0 was already driven (previous TAIL or an abort START).
    task automatic frame(input int ovf_cyc, input bit chained_in,
                         input bit start_tail, input bit rnd_ed);
        bit fo;
        int newcur;
        fo = 0;
        for (int c = (chained_in ? 1 : 0); c <= FRAME; c++) begin
            ed_gaps(rnd_ed);
            if (c == 0) m_cur = m_nxt;
            if (c >= 1 && c == ovf_cyc) fo = 1;
            if (c == FRAME) begin
                sbq.push_back({m_cur[1:0], fo});
                newcur = m_nxt;
                model_decide(fo);
                if (start_tail) m_cur = newcur;
            end
            tick(1'b1, (c == 0 && !chained_in) || (c == FRAME && start_tail), c == ovf_cyc);
            if (c == 1) begin
                chk("shift_in_frame", 8'(SHIFT), 8'(m_cur));
                chk("abort_quiet", 8'(ABORT), 8'd0);
            end
        end
    endtask

    // Scoreboard consumer
    always @(negedge CLK) begin
        if (!RST && EXP_VLD) begin
            chk("sb_underflow", 8'(sbq.size() == 0), 8'd0);
            if (sbq.size() > 0) begin
                sb_t e;
                e = sbq.pop_front();
                chk("exp", 8'(EXP), 8'(e.exp));
                chk("frm_ovf", 8'(FRM_OVF), 8'(e.fo));
            end
        end
    end

    initial begin
        RST = 1'b1; ED = 1'b0; START = 1'b0; OVF = 1'b0;
        do_reset();

        // reset state
        chk("rst_shift", 8'(SHIFT), 8'd2);
        chk("rst_exp", 8'(EXP), 8'd0);
        chk("rst_exp_vld", 8'(EXP_VLD), 8'd0);
        chk("rst_frm_ovf", 8'(FRM_OVF), 8'd0);
        chk("rst_abort", 8'(ABORT), 8'd0);
        chk("rst_sat", 8'(SAT), 8'd0);

        // clean frame, then an overflowing one, then back-off visible
        frame(-1, 0, 0, 0);
        tick(1'b1, 1'b0, 1'b1);
        frame(100, 0, 0, 0);
        tick(1'b1, 1'b0, 1'b0);
        frame(-1, 0, 0, 0);
        chk("shift_backoff", 8'(SHIFT), 8'd1);

        // growth after HOLD clean frames, then saturation at MAX_SHIFT;
        // OVF in the START cycle of the first frame is stale
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            frame(i == 0 ? 0 : -1, 0, 0, 0);
        end
        tick(1'b1, 1'b0, 1'b0);
        frame(-1, 0, 0, 0);
        chk("shift_grow", 8'(SHIFT), 8'd3);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            frame(-1, 0, 0, 0);
        end
        chk("shift_max", 8'(SHIFT), 8'd3);

        // back-to-back frames, overflow only in the TAIL cycle of frame 1
        do_reset();
        frame(FRAME, 0, 1, 0);
        chk("b2b_f2_shift", 8'(SHIFT), 8'd2);
        frame(-1, 1, 1, 0);
        chk("b2b_f3_shift", 8'(SHIFT), 8'd1);
        frame(-1, 1, 0, 0);

        // repeated overflow down to 0, SAT sticky
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            frame(100, 0, 0, 0);
            if (i == 1) chk("sat_not_yet", 8'(SAT), 8'd0);
            if (i == 2) chk("sat_set", 8'(SAT), 8'd1);
        end
        chk("shift_floor", 8'(SHIFT), 8'd0);
        tick(1'b1, 1'b0, 1'b0);
        frame(-1, 0, 0, 0);
        chk("sat_sticky", 8'(SAT), 8'(m_sat));

        // reset mid-frame: no report for the partial frame
        for (int c = 0; c < 30; c++) tick(1'b1, c == 0, c == 10);
        do_reset();
        chk("midrst_sat", 8'(SAT), 8'd0);
        chk("midrst_shift", 8'(SHIFT), 8'd2);
        for (int c = 0; c < FRAME + 4; c++) tick(1'b1, 1'b0, 1'b1);
        chk("midrst_exp", 8'(EXP), 8'd0);

        // early START at sample 50 after an overflow, random ED
        do_reset();
        m_cur = m_nxt;
        for (int c = 0; c <= 50; c++) begin
            ed_gaps(1);
            tick(1'b1, c == 0 || c == 50, c == 20);
        end
        chk("abort_pulse", 8'(ABORT), 8'd1);
        m_cur = m_nxt;
        frame(-1, 1, 0, 1);
        tick(1'b1, 1'b0, 1'b0);
        frame(-1, 0, 0, 0);
        chk("shift_after_abort", 8'(SHIFT), 8'd2);

        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk("sb_drained", 8'(sbq.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnorm_shift_ctrl.md
Name: cnorm_shift_ctrl

Overview:
- Block-floating-point scaling controller for the FFT256 output normalizer (CNORM).
- Counts frame samples and watches the normalizer's overflow flag. Selects the 2-bit left-shift code per frame: back off after any overflow, grow after HOLD clean frames.
- Reports the shift used for each completed frame as a block exponent.
- Sits between the FFT core's frame-start/enable strobes and the normalizer's SHIFT input.

Parameters:
- FRAME, 256, samples per frame (power of 2); counter width is log2(FRAME).
- HOLD, 4, consecutive clean frames required before shift is incremented (1..15).
- INIT_SHIFT, 2, shift code after reset (0..MAX_SHIFT).
- MAX_SHIFT, 3, upper bound of shift code (≤3).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ED  in  1  enable/data-valid; every state change is qualified by ED.
- START  in  1  frame start, same cycle as sample 0 (also driven to normalizer).
- OVF  in  1  normalizer overflow flag; a 1 in the cycle of sample j reports sample j-1.
- SHIFT  out  2  shift code to normalizer, constant over a frame.
- EXP  out  2  shift code that was applied to the frame just closed.
- EXP_VLD  out  1  one-cycle pulse, EXP valid.
- FRM_OVF  out  1  with EXP_VLD: the closed frame overflowed.
- ABORT  out  1  one-cycle pulse, START arrived mid-frame.
- SAT  out  1  sticky: overflow occurred while shift was 0; cleared only by RST.

Behaviour:
- Reset: state IDLE, SHIFT=shift_nxt=INIT_SHIFT, cnt=0, clean_cnt=0, ovf_acc=0, EXP=0, EXP_VLD=FRM_OVF=ABORT=SAT=0.
- ED low: all registers hold and pulses deassert. ED qualifies everything below.
- Registers:
  - shift_cur drives SHIFT.
  - shift_nxt holds the policy result.
  - SHIFT loads shift_nxt only on an accepted START, so SHIFT never changes inside a frame.
- States:
  - IDLE: on START, go to RUN. Load shift_cur from shift_nxt, set cnt=1, clear ovf_acc.
  - RUN: each ED does ovf_acc |= OVF and cnt++.
    - When cnt==FRAME-1 (last sample), go to TAIL.
    - START while in RUN means an early frame. Pulse ABORT, discard ovf_acc (no decision), restart: cnt=1, load shift_cur from shift_nxt.
  - TAIL (captures the last sample's OVF): on ED, frame_ovf = ovf_acc | OVF, then run the decision.
    - Pulse EXP_VLD with EXP=shift_cur and FRM_OVF=frame_ovf.
    - If START is also present, go to RUN and load shift_cur from the old shift_nxt (the value before this decision). Otherwise go to IDLE.
- Decision, at most once per completed frame:
  - frame_ovf=1, shift_nxt>0: shift_nxt−1, clean_cnt=0.
  - frame_ovf=1, shift_nxt==0: shift_nxt stays 0, SAT=1, clean_cnt=0.
  - frame_ovf=0: clean_cnt+1. When it reaches HOLD: shift_nxt=min(shift_nxt+1, MAX_SHIFT), clean_cnt=0.
- Latency:
  - With back-to-back frames, SHIFT for frame k+1 reflects decisions up to frame k−1 (one-frame lag).
  - With an idle gap of ≥1 ED cycle, it reflects frame k.
- OVF in the START cycle of a fresh frame from IDLE is ignored (stale).
- RST mid-frame: immediate return to reset values. No EXP_VLD for the partial frame.
- EXP is held between pulses.

Decomposition:
- Shared fft256 package: state encoding (IDLE/RUN/TAIL), 2-bit shift-code type, FRAME/log2 constant shared with the FFT core and the normalizer.
- One natural sub-module, shift_policy: combinational/registered decision (shift_nxt, clean_cnt, SAT) driven by frame_ovf and a decide strobe. Frame sequencing FSM plus counter stays in the top.

Test Plan:
- Reset, START with ED=1, 256 samples, OVF=0 throughout → SHIFT=2 all frame; EXP_VLD at TAIL with EXP=2, FRM_OVF=0; return to IDLE.
- Frames separated by an idle cycle, OVF=1 once at sample 100 of frame 1 → frame 1 EXP=2, FRM_OVF=1; frame 2 SHIFT=1; clean_cnt reset.
- Four clean gapped frames at SHIFT=2 → frame 5 SHIFT=3. Then four more clean frames → SHIFT stays 3 (MAX_SHIFT).
- Back-to-back frames (START in the TAIL cycle), OVF only in the TAIL cycle of frame 1 → frame 1 FRM_OVF=1; frame 2 SHIFT=2 (lag); frame 3 SHIFT=1.
- Repeated overflowing frames from INIT 2 → SHIFT 2,1,0,0; SAT=1 after the third overflow frame at shift 0, stays 1 until RST.
- START at sample 50 of a frame with OVF=1 earlier → ABORT pulse, no EXP_VLD, shift_nxt unchanged, cnt restarts. ED toggled 0/1 randomly: frame closes after exactly 256 ED-high cycles.
